// File: rtl/pellet_loader.sv
// pellet_loader: streams the level layout ROM into the tile RAM and tracks remaining pellets.
// Ports: Clk/Reset_n (async active-low); start requests a level load (IDLE only);
//   pellet_eaten is a one-cycle eat pulse; layout_addr/layout_data form the ROM
//   read port (1-cycle latency); ram_addr/ram_din/ram_we form the tile RAM write
//   port; busy marks ownership of that port; done pulses at load end;
//   pellets_left counts remaining pellets; level_clear flags an eaten-out level.
module pellet_loader #(
  parameter int TILES = 868,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 9,
  parameter logic [DATA_W-1:0] REG_PELLET = 9'h063,
  parameter logic [DATA_W-1:0] POWER_PELLET = 9'h062
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic              pellet_eaten,
  output logic [ADDR_W-1:0] layout_addr,
  input  logic [DATA_W-1:0] layout_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pellets_left,
  output logic              level_clear
);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TILES - 1);
  state_t state, next;
  logic [ADDR_W-1:0] rd_addr, addr_q;
  logic valid_q, loaded, go, is_pellet;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state == IDLE  ? (start ? LOAD : IDLE) :
           state == LOAD  ? (rd_addr == LAST ? DRAIN : LOAD) :
           state == DRAIN ? DONE : IDLE;
    go = state == IDLE && start;
    busy = state == LOAD || state == DRAIN;
    done = state == DONE;
    layout_addr = state == LOAD ? rd_addr : '0;
    level_clear = state == IDLE && loaded && pellets_left == '0;
  end
  // ROM data arrives one cycle after its address, so the write side is driven
  // from the delayed address/valid pair; outputs are forced to 0 when idle.
  assign ram_we = valid_q;
  assign ram_addr = valid_q ? addr_q : '0;
  assign ram_din = valid_q ? layout_data : '0;
  assign is_pellet = layout_data == REG_PELLET || layout_data == POWER_PELLET;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      rd_addr <= '0;
      addr_q <= '0;
      valid_q <= 1'b0;
      loaded <= 1'b0;
      pellets_left <= '0;
    end else begin
      rd_addr <= state == LOAD ? rd_addr + ADDR_W'(1) : '0;
      addr_q <= rd_addr;
      valid_q <= state == LOAD;
      loaded <= go ? 1'b0 : state == DONE ? 1'b1 : loaded;
      // start beats a same-cycle eat; eats are only honoured in IDLE.
      pellets_left <= go ? '0 :
                      valid_q && is_pellet ? pellets_left + ADDR_W'(1) :
                      state == IDLE && pellet_eaten && pellets_left != '0 ? pellets_left - ADDR_W'(1) :
                      pellets_left;
    end
endmodule

// File: tb/tb_pellet_loader.sv
// tb_pellet_loader: directed self-checking bench for pellet_loader with TILES=16.
module tb_pellet_loader;
  localparam int TILES = 16;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 9;
  logic Clk = 1'b0, Reset_n = 1'b0, start = 1'b0, pellet_eaten = 1'b0;
  logic [ADDR_W-1:0] layout_addr, ram_addr, pellets_left;
  logic [DATA_W-1:0] layout_data = '0, ram_din;
  logic ram_we, busy, done, level_clear;
  logic [DATA_W-1:0] rom [TILES];
  bit rnd = 1'b1;
  int cyc = 0, total = 0, bad = 0;
  int done_cnt = 0, done_cyc = -1, first_wr_cyc = -1;
  bit busy_at_done = 1'b1;
  logic [ADDR_W-1:0] wr_addr [$];
  logic [DATA_W-1:0] wr_data [$];

  pellet_loader #(.TILES(TILES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .pellet_eaten(pellet_eaten),
    .layout_addr(layout_addr), .layout_data(layout_data), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_we(ram_we), .busy(busy), .done(done),
    .pellets_left(pellets_left), .level_clear(level_clear)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  always @(posedge Clk) layout_data <= rnd ? DATA_W'($urandom) : rom[layout_addr[3:0]];
  always @(negedge Clk) begin
    if (ram_we) begin
      if (wr_addr.size() == 0) first_wr_cyc = cyc;
      wr_addr.push_back(ram_addr);
      wr_data.push_back(ram_din);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = busy;
    end
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
    done_cyc = -1;
    first_wr_cyc = -1;
    busy_at_done = 1'b1;
  endtask

  task automatic start_load(output int k);
    @(posedge Clk);
    #1 start = 1'b1;
    @(posedge Clk);
    #1 k = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    for (int i = 0; i < 40 && done_cnt == 0; i++) @(negedge Clk);
    ok = done_cnt != 0;
    repeat (2) @(posedge Clk);
    #1;
  endtask

  task automatic eat_pulse();
    @(posedge Clk);
    #1 pellet_eaten = 1'b1;
    @(posedge Clk);
    #1 pellet_eaten = 1'b0;
  endtask

  task automatic test_reset();
    logic [3*ADDR_W+DATA_W+5-1:0] outs;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk);
      #1 start = 1'($urandom);
      pellet_eaten = 1'($urandom);
      @(negedge Clk);
      outs = {layout_addr, ram_addr, pellets_left, ram_din, ram_we, busy, done, level_clear, 1'b0};
      total++;
      if (outs !== '0) begin
        bad++;
        $display("FAIL reset_outputs[%0d] got=%h want=0", i, outs);
      end
    end
    @(posedge Clk);
    #1 start = 1'b0;
    pellet_eaten = 1'b0;
    rnd = 1'b0;
    Reset_n = 1'b1;
    repeat (3) eat_pulse();
    total++;
    if (pellets_left !== '0) begin
      bad++;
      $display("FAIL reset_eat_pellets got=%0d want=0", pellets_left);
    end
    total++;
    if (level_clear !== 1'b0) begin
      bad++;
      $display("FAIL reset_eat_clear got=%b want=0", level_clear);
    end
  endtask

  task automatic test_full_load();
    int k;
    bit ok;
    clear_log();
    start_load(k);
    wait_done(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL load_done_timeout got=0 want=1");
    end
    total++;
    if (wr_addr.size() != TILES) begin
      bad++;
      $display("FAIL load_write_count got=%0d want=%0d", wr_addr.size(), TILES);
    end
    for (int i = 0; i < TILES && i < wr_addr.size(); i++) begin
      total++;
      if (wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== rom[i]) begin
        bad++;
        $display("FAIL load_write[%0d] got=%0d:%h want=%0d:%h", i, wr_addr[i], wr_data[i], i, rom[i]);
      end
    end
    total++;
    if (first_wr_cyc != k + 1) begin
      bad++;
      $display("FAIL load_first_write_cycle got=%0d want=%0d", first_wr_cyc, k + 1);
    end
    total++;
    if (done_cnt != 1 || done_cyc != k + TILES + 1) begin
      bad++;
      $display("FAIL load_done_pulse got=%0d@%0d want=1@%0d", done_cnt, done_cyc, k + TILES + 1);
    end
    total++;
    if (busy_at_done !== 1'b0) begin
      bad++;
      $display("FAIL load_busy_at_done got=%b want=0", busy_at_done);
    end
    total++;
    if (pellets_left !== ADDR_W'(4) || level_clear !== 1'b0) begin
      bad++;
      $display("FAIL load_pellets got=%0d/%b want=4/0", pellets_left, level_clear);
    end
  endtask

  task automatic test_eat_out();
    int k;
    bit ok;
    for (int i = 0; i < 5; i++) begin
      eat_pulse();
      total++;
      if (pellets_left !== ADDR_W'(i < 4 ? 3 - i : 0) || level_clear !== (i >= 3)) begin
        bad++;
        $display("FAIL eat[%0d] got=%0d/%b want=%0d/%b", i, pellets_left, level_clear, i < 4 ? 3 - i : 0, i >= 3);
      end
    end
    clear_log();
    start_load(k);
    total++;
    if (level_clear !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL eat_restart got=clear%b busy%b want=clear0 busy1", level_clear, busy);
    end
    wait_done(ok);
    total++;
    if (!ok || pellets_left !== ADDR_W'(4)) begin
      bad++;
      $display("FAIL eat_reload got=%0d done=%b want=4 done=1", pellets_left, ok);
    end
  endtask

  task automatic test_busy_ignore();
    int k;
    bit ok;
    clear_log();
    start_load(k);
    repeat (4) @(posedge Clk);
    #1 start = 1'b1;
    pellet_eaten = 1'b1;
    @(posedge Clk);
    #1 start = 1'b0;
    pellet_eaten = 1'b0;
    wait_done(ok);
    repeat (20) @(posedge Clk);
    #1;
    total++;
    if (!ok || wr_addr.size() != TILES || done_cnt != 1) begin
      bad++;
      $display("FAIL busy_ignore_writes got=%0d/%0d want=%0d/1", wr_addr.size(), done_cnt, TILES);
    end
    total++;
    if (pellets_left !== ADDR_W'(4) || busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_ignore_pellets got=%0d/%b want=4/0", pellets_left, busy);
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    repeat (2) eat_pulse();
    total++;
    if (pellets_left !== ADDR_W'(2)) begin
      bad++;
      $display("FAIL simul_setup got=%0d want=2", pellets_left);
    end
    clear_log();
    @(posedge Clk);
    #1 start = 1'b1;
    pellet_eaten = 1'b1;
    @(posedge Clk);
    #1 start = 1'b0;
    pellet_eaten = 1'b0;
    total++;
    if (busy !== 1'b1 || pellets_left !== '0) begin
      bad++;
      $display("FAIL simul_start got=busy%b/%0d want=busy1/0", busy, pellets_left);
    end
    wait_done(ok);
    total++;
    if (!ok || wr_addr.size() != TILES || pellets_left !== ADDR_W'(4)) begin
      bad++;
      $display("FAIL simul_reload got=%0d/%0d want=%0d/4", wr_addr.size(), pellets_left, TILES);
    end
  endtask

  task automatic test_mid_reset();
    int k;
    bit ok;
    clear_log();
    start_load(k);
    repeat (8) @(posedge Clk);
    #1;
    total++;
    if (ram_we !== 1'b1 || ram_addr !== ADDR_W'(7)) begin
      bad++;
      $display("FAIL midreset_pre got=%b@%0d want=1@7", ram_we, ram_addr);
    end
    #2 Reset_n = 1'b0;
    #1;
    total++;
    if (ram_we !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset_async got=we%b busy%b want=we0 busy0", ram_we, busy);
    end
    repeat (3) @(posedge Clk);
    #1 Reset_n = 1'b1;
    repeat (25) @(posedge Clk);
    #1;
    total++;
    if (done_cnt != 0 || wr_addr.size() != 7 || level_clear !== 1'b0) begin
      bad++;
      $display("FAIL midreset_abort got=done%0d wr%0d clr%b want=done0 wr7 clr0", done_cnt, wr_addr.size(), level_clear);
    end
    clear_log();
    start_load(k);
    wait_done(ok);
    total++;
    if (!ok || wr_addr.size() != TILES || done_cnt != 1 || pellets_left !== ADDR_W'(4)) begin
      bad++;
      $display("FAIL midreset_reload got=wr%0d done%0d p%0d want=wr%0d done1 p4", wr_addr.size(), done_cnt, pellets_left, TILES);
    end
  endtask

  initial begin
    for (int i = 0; i < TILES; i++) rom[i] = 9'h1FF;
    rom[1] = 9'h063;
    rom[2] = 9'h063;
    rom[5] = 9'h063;
    rom[9] = 9'h062;
    test_reset();
    test_full_load();
    test_eat_out();
    test_busy_ignore();
    test_simultaneous();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
